alu_pipe: RTL and testbench



---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_mul_iter.sv | 53 +++++
 rtl/alu_pipe.sv | 147 ++++++++++++++
 tb/tb_alu_pipe.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and default width for the pipelined ALU and its iterative multiplier.
package alu_pkg;

  localparam int DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_MUL = 3'd7
  } alu_opcode_t;

  typedef struct packed {
    logic zero;
    logic negative;
    logic carry;
    logic overflow;
  } alu_flags_t;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } alu_state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier, one partial product per clock.
// Only instantiated when ALU_PIPE_MUL_EN is defined.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int W = alu_pkg::DATA_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] product,
  output logic         carry
);

  localparam int CW = $clog2(W + 1);

  logic [CW-1:0]  count_reg;
  logic [2*W-1:0] acc_reg;
  logic [2*W-1:0] mcand_reg;
  logic [W-1:0]   mplier_reg;
  logic [2*W-1:0] acc_next;

  assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg  <= '0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
    end else if (start) begin
      count_reg  <= CW'(W);
      acc_reg    <= '0;
      mcand_reg  <= {{W{1'b0}}, a};
      mplier_reg <= b;
    end else if (count_reg != '0) begin
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      count_reg  <= count_reg - CW'(1);
    end
  end

  // The final step's sum is presented combinationally so the caller can
  // capture it on the same edge that retires the last partial product.
  assign done    = (count_reg == CW'(1));
  assign product = acc_next[W-1:0];
  assign carry   = |acc_next[2*W-1:W];

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready on both sides; single-cycle ops have latency 1.
// Define ALU_PIPE_MUL_EN to include the iterative multiplier (MUL_BUSY state).
module alu_pipe
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  alu_opcode_t           op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output alu_flags_t            flags
);

  localparam int SHAMT_W = $clog2(DATA_WIDTH);

  alu_state_t            state_reg, state_next;
  logic                  out_valid_reg, out_valid_next;
  logic [DATA_WIDTH-1:0] result_reg, result_next;
  alu_flags_t            flags_reg, flags_next;

  logic [DATA_WIDTH-1:0] alu_result;
  alu_flags_t            alu_flags;
  logic [DATA_WIDTH:0]   wide;

  logic                  accept;
  logic                  pop;
  logic                  mul_start;
  logic                  mul_done;
  logic [DATA_WIDTH-1:0] mul_product;
  logic                  mul_carry;

  assign in_ready = (state_reg == IDLE) && (!out_valid_reg || out_ready);
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid_reg && out_ready;

`ifdef ALU_PIPE_MUL_EN
  assign mul_start = accept && (op == ALU_MUL);

  alu_mul_iter #(.W(DATA_WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product),
    .carry   (mul_carry)
  );
`else
  assign mul_start   = 1'b0;
  assign mul_done    = 1'b0;
  assign mul_product = '0;
  assign mul_carry   = 1'b0;
`endif

  // Single-cycle datapath; MUL lands in default when the multiplier is absent.
  always_comb begin
    alu_result = '0;
    alu_flags  = '0;
    wide       = '0;
    case (op)
      ALU_ADD: begin
        wide               = {1'b0, a} + {1'b0, b};
        alu_result         = wide[DATA_WIDTH-1:0];
        alu_flags.carry    = wide[DATA_WIDTH];
        alu_flags.overflow = (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) &&
                             (alu_result[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
      end
      ALU_SUB: begin
        wide               = {1'b0, a} - {1'b0, b};
        alu_result         = wide[DATA_WIDTH-1:0];
        alu_flags.carry    = wide[DATA_WIDTH];
        alu_flags.overflow = (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) &&
                             (alu_result[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
      end
      ALU_AND: alu_result = a & b;
      ALU_OR:  alu_result = a | b;
      ALU_XOR: alu_result = a ^ b;
      ALU_SLL: alu_result = a << b[SHAMT_W-1:0];
      ALU_SRL: alu_result = a >> b[SHAMT_W-1:0];
      default: alu_result = '0;
    endcase
    alu_flags.zero     = (alu_result == '0);
    alu_flags.negative = alu_result[DATA_WIDTH-1];
  end

  always_comb begin
    state_next     = state_reg;
    out_valid_next = out_valid_reg;
    result_next    = result_reg;
    flags_next     = flags_reg;
    if (pop) begin
      out_valid_next = 1'b0;
    end
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (mul_start) begin
            state_next = MUL_BUSY;
          end else begin
            out_valid_next = 1'b1;
            result_next    = alu_result;
            flags_next     = alu_flags;
          end
        end
      end
      MUL_BUSY: begin
        if (mul_done) begin
          state_next          = IDLE;
          out_valid_next      = 1'b1;
          result_next         = mul_product;
          flags_next.zero     = (mul_product == '0);
          flags_next.negative = mul_product[DATA_WIDTH-1];
          flags_next.carry    = mul_carry;
          flags_next.overflow = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      flags_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      out_valid_reg <= out_valid_next;
      result_reg    <= result_next;
      flags_reg     <= flags_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign flags     = flags_reg;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed handshake cases plus a randomized
// stream scored against an arithmetic reference model. Honours ALU_PIPE_MUL_EN.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W = alu_pkg::DATA_WIDTH;
`ifdef ALU_PIPE_MUL_EN
  localparam int MUL_LAT = W;
`else
  localparam int MUL_LAT = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  alu_opcode_t op;
  logic        out_valid;
  logic        out_ready;
  logic [W-1:0] result;
  alu_flags_t  flags;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  logic [W+3:0] exp_q[$];
  logic [W+3:0] exp_v[4];

  alu_pipe #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {result, zero, negative, carry, overflow} from plain integer arithmetic.
  function automatic logic [W+3:0] model(alu_opcode_t o, logic [W-1:0] x, logic [W-1:0] y);
    longint m   = longint'(1) << W;
    longint shm = longint'(1) << $clog2(W);
    longint ux  = longint'(x);
    longint uy  = longint'(y);
    longint sx  = x[W-1] ? ux - m : ux;
    longint sy  = y[W-1] ? uy - m : uy;
    longint r   = 0;
    longint s   = 0;
    bit     c   = 0;
    bit     v   = 0;
    case (o)
      ALU_ADD: begin
        r = (ux + uy) % m;  c = (ux + uy) >= m;
        s = sx + sy;        v = (s >= m / 2) || (s < -(m / 2));
      end
      ALU_SUB: begin
        r = (ux - uy + m) % m;  c = ux < uy;
        s = sx - sy;            v = (s >= m / 2) || (s < -(m / 2));
      end
      ALU_AND: r = ux & uy;
      ALU_OR:  r = ux | uy;
      ALU_XOR: r = ux ^ uy;
      ALU_SLL: r = (ux << (uy % shm)) % m;
      ALU_SRL: r = ux >> (uy % shm);
      default: begin
`ifdef ALU_PIPE_MUL_EN
        r = (ux * uy) % m;  c = (ux * uy) >= m;
`else
        r = 0;
`endif
      end
    endcase
    return {r[W-1:0], (r == 0), (r >= m / 2), c, v};
  endfunction

  // Issue one op from IDLE with out_ready=1 and check latency, busy cycles and output.
  task automatic txn(input string tag, input alu_opcode_t o, input logic [W-1:0] x,
                     input logic [W-1:0] y, input logic [W-1:0] er, input logic [3:0] ef,
                     input int elat);
    int waited = 0;
    int busy = 0;
    in_valid = 1'b1; op = o; a = x; b = y; out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && waited < 64) begin
      if (!in_ready) busy++;
      waited++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, 32'(waited), 32'(elat));
    chk({tag, "_busy"}, 32'(busy), 32'(elat));
    chk({tag, "_result"}, 32'(result), 32'(er));
    chk({tag, "_flags"}, 32'(flags), 32'(ef));
    $display("txn %s op=%0d a=%h b=%h -> result=%h flags=%b wait=%0d", tag, o, x, y, result, flags, waited);
  endtask

  initial begin
    int cnt;
    logic [W+3:0] e;

    // Reset state
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = ALU_ADD; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_flags", 32'(flags), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed ops; flags are {zero, negative, carry, overflow}
    txn("add_ff_01", ALU_ADD, 8'hFF, 8'h01, 8'h00, 4'b1010, 0);
    txn("sub_80_01", ALU_SUB, 8'h80, 8'h01, 8'h7F, 4'b0001, 0);
    txn("sub_01_02", ALU_SUB, 8'h01, 8'h02, 8'hFF, 4'b0110, 0);
`ifdef ALU_PIPE_MUL_EN
    txn("mul_20_13", ALU_MUL, 8'd20, 8'd13, 8'h04, 4'b0010, MUL_LAT);
`else
    txn("mul_20_13", ALU_MUL, 8'd20, 8'd13, 8'h00, 4'b1000, MUL_LAT);
`endif
    txn("sll_01_0b", ALU_SLL, 8'h01, 8'h0B, 8'h08, 4'b0000, 0);
    txn("srl_80_0a", ALU_SRL, 8'h80, 8'h0A, 8'h20, 4'b0000, 0);

    // Backpressure: ADD 3+4 held, XOR pending, then pop and accept on the same edge
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; op = ALU_ADD; a = 8'd3; b = 8'd4; out_ready = 1'b0;
    @(negedge clk);
    op = ALU_XOR; a = 8'hF0; b = 8'h0F;
    for (int i = 0; i < 3; i++) begin
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_result", 32'(result), 32'd7);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      $display("hold cycle %0d result=%h in_ready=%b", i, result, in_ready);
      if (i < 2) @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("pop_accept_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("pop_accept_valid", 32'(out_valid), 32'd1);
    chk("pop_accept_result", 32'(result), 32'hFF);
    chk("pop_accept_flags", 32'(flags), 32'b0100);
    $display("pop+accept xor -> result=%h flags=%b", result, flags);
    @(negedge clk);
    chk("drained_valid", 32'(out_valid), 32'd0);

    // Four back-to-back single-cycle ops with out_ready=1
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      op = alu_opcode_t'($urandom_range(0, 6));
      a = W'($urandom); b = W'($urandom);
      exp_v[i] = model(op, a, b);
      @(negedge clk);
      chk("b2b_valid", 32'(out_valid), 32'd1);
      chk("b2b_result", 32'(result), 32'(exp_v[i][W+3:4]));
      chk("b2b_flags", 32'(flags), 32'(exp_v[i][3:0]));
      $display("b2b %0d result=%h flags=%b", i, result, flags);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_end_valid", 32'(out_valid), 32'd0);

    // Randomized stream with random valid/ready against the reference model
    exp_q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("stream_unexpected_output", 32'(exp_q.size()), 32'd1);
        end else begin
          chk("stream_result", 32'(result), 32'(exp_q[0][W+3:4]));
          chk("stream_flags", 32'(flags), 32'(exp_q[0][3:0]));
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 1) != 0);
      op = alu_opcode_t'($urandom_range(0, 7));
      a = W'($urandom); b = W'($urandom);
      #1;
      if (out_valid && out_ready) begin
        $display("stream pop result=%h flags=%b", result, flags);
        void'(exp_q.pop_front());
      end
      if (in_valid && in_ready) exp_q.push_back(model(op, a, b));
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < W + 8) begin
      if (out_valid) begin
        e = exp_q.pop_front();
        chk("drain_result", 32'(result), 32'(e[W+3:4]));
        chk("drain_flags", 32'(flags), 32'(e[3:0]));
        $display("drain pop result=%h flags=%b", result, flags);
      end
      cnt++;
      @(negedge clk);
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);

    // Reset in the middle of a MUL: no stale result may appear afterwards
    in_valid = 1'b1; op = ALU_MUL; a = 8'd20; b = 8'd13; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midmul_rst_out_valid", 32'(out_valid), 32'd0);
    chk("midmul_rst_in_ready", 32'(in_ready), 32'd1);
    chk("midmul_rst_result", 32'(result), 32'd0);
    chk("midmul_rst_flags", 32'(flags), 32'd0);
    $display("reset mid-MUL: out_valid=%b in_ready=%b result=%h", out_valid, in_ready, result);
    cnt = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("midmul_no_stale", 32'(cnt), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
